cpu_sequencer: RTL and testbench

- Control sequencer for the 8-bit accumulator CPU.
- Steps a fixed 8-phase instruction cycle and drives the strobes for memory, instruction register (IR), program counter (PC) and accumulator load around the shared ALU.
- Adds a sticky halt with a resume handshake.
- Sits between IR/opcode decode, the ALU zero flag, and the datapath register enables.

---
 rtl/cpu_rtl_pkg.sv | 34 +++
 rtl/cpu_seq_decode.sv | 71 +++++++
 rtl/cpu_sequencer.sv | 79 +++++++
 tb/tb_cpu_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_rtl_pkg.sv
// rtl/cpu_rtl_pkg.sv - opcode and phase types shared by the accumulator CPU sequencer
package cpu_rtl_pkg;

    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } state_t;

    // Opcodes that read an operand and write the accumulator; anything else is a NOP here.
    function automatic logic is_aluop(input opcode_t op);
        case (op)
            ADD, AND, XOR, LDA: is_aluop = 1'b1;
            default:            is_aluop = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_seq_decode.sv
// rtl/cpu_seq_decode.sv - combinational phase/opcode/zero to datapath strobe decode
module cpu_seq_decode
    import cpu_rtl_pkg::*;
(
    input  logic [2:0] phase,
    input  logic [2:0] opcode,
    input  logic       zero,
    input  logic       en,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       load_ir,
    output logic       load_ac,
    output logic       inc_pc,
    output logic       load_pc
);

    logic alu;
    logic is_skz;
    logic is_jmp;
    logic is_sto;

    // Equality via case so an unknown opcode falls through to "no match" instead of X.
    always_comb begin
        is_skz = 1'b0;
        is_jmp = 1'b0;
        is_sto = 1'b0;
        case (opcode_t'(opcode))
            SKZ:     is_skz = 1'b1;
            JMP:     is_jmp = 1'b1;
            STO:     is_sto = 1'b1;
            default: ;
        endcase
        alu = is_aluop(opcode_t'(opcode));
    end

    always_comb begin
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        load_ir = 1'b0;
        load_ac = 1'b0;
        inc_pc  = 1'b0;
        load_pc = 1'b0;
        if (en) begin
            case (state_t'(phase))
                INST_ADDR: ;
                INST_FETCH: mem_rd = 1'b1;
                INST_LOAD, IDLE: begin
                    mem_rd  = 1'b1;
                    load_ir = 1'b1;
                end
                OP_ADDR: inc_pc = 1'b1;
                OP_FETCH: mem_rd = alu;
                ALU_OP: begin
                    mem_rd  = alu;
                    load_ac = alu;
                    inc_pc  = is_skz & zero;
                    load_pc = is_jmp;
                end
                STORE: begin
                    mem_rd  = alu;
                    load_ac = alu;
                    inc_pc  = is_jmp;
                    load_pc = is_jmp;
                    mem_wr  = is_sto;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - 8-phase CPU control sequencer with sticky halt; CPU_SEQ_INSTR_CNT_EN adds instr_cnt
module cpu_sequencer
    import cpu_rtl_pkg::*;
#(
    parameter int CNT_W = 16
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       zero,
    input  logic       go,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       load_ir,
    output logic       load_ac,
    output logic       inc_pc,
    output logic       load_pc,
    output logic       halt,
    output logic [2:0] phase
`ifdef CPU_SEQ_INSTR_CNT_EN
    ,
    output logic [CNT_W-1:0] instr_cnt
`endif
);

    state_t phase_q;
    logic   halted;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= INST_ADDR;
            halted  <= 1'b0;
        end else if (halted) begin
            // Resume skips the operand fetch, so the HLT instruction retires as a NOP.
            if (go) begin
                halted  <= 1'b0;
                phase_q <= ALU_OP;
            end
        end else if (phase_q == OP_ADDR && opcode == 3'(HLT)) begin
            halted  <= 1'b1;
            phase_q <= OP_FETCH;
        end else begin
            phase_q <= state_t'(phase_q + 3'd1);
        end
    end

`ifdef CPU_SEQ_INSTR_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (!halted && phase_q == STORE) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign instr_cnt = cnt_q;
`endif

    // Strobes stay low during a reset cycle even though phase_q has not yet been cleared.
    cpu_seq_decode u_decode (
        .phase   (phase_q),
        .opcode  (opcode),
        .zero    (zero),
        .en      (!rst && !halted),
        .mem_rd  (mem_rd),
        .mem_wr  (mem_wr),
        .load_ir (load_ir),
        .load_ac (load_ac),
        .inc_pc  (inc_pc),
        .load_pc (load_pc)
    );

    assign halt  = halted;
    assign phase = phase_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - scoreboard bench for cpu_sequencer
module tb_cpu_sequencer;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] opcode;
    logic       zero;
    logic       go;
    logic       mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc, halt;
    logic [2:0] phase;
`ifdef CPU_SEQ_INSTR_CNT_EN
    logic [3:0] instr_cnt;
`endif

    cpu_sequencer #(.CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .zero      (zero),
        .go        (go),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .load_ir   (load_ir),
        .load_ac   (load_ac),
        .inc_pc    (inc_pc),
        .load_pc   (load_pc),
        .halt      (halt),
        .phase     (phase)
`ifdef CPU_SEQ_INSTR_CNT_EN
        ,
        .instr_cnt (instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] ph;
        logic       hl;
        logic [5:0] str;
        logic [3:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic [2:0] m_ph;
    logic       m_hl;
    logic [3:0] m_cnt;

    // {mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc}
    function automatic logic [5:0] exp_str(input logic [2:0] ph, input logic [2:0] op,
                                           input logic z, input logic hl, input logic r);
        logic alu;
        alu = (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
        if (hl || r) return 6'b0;
        case (ph)
            3'd1:    return 6'b100000;
            3'd2:    return 6'b101000;
            3'd3:    return 6'b101000;
            3'd4:    return 6'b000010;
            3'd5:    return {alu, 5'b0};
            3'd6:    return {alu, 1'b0, 1'b0, alu, (op == OP_SKZ) && z, op == OP_JMP};
            3'd7:    return {alu, op == OP_STO, 1'b0, alu, op == OP_JMP, op == OP_JMP};
            default: return 6'b0;
        endcase
    endfunction

    task automatic step(input logic r, input logic [2:0] op, input logic z, input logic g);
        exp_t e;
        rst = r;
        opcode = op;
        zero = z;
        go = g;
        #1;
        sb.push_back('{ph: m_ph, hl: m_hl, str: exp_str(m_ph, op, z, m_hl, r), cnt: m_cnt});
        e = sb.pop_front();
        checks++;
        if (phase !== e.ph) begin
            errors++;
            $display("FAIL phase: got %0d expected %0d at %0t", phase, e.ph, $time);
        end
        checks++;
        if (halt !== e.hl) begin
            errors++;
            $display("FAIL halt: got %0b expected %0b at %0t", halt, e.hl, $time);
        end
        checks++;
        if ({mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc} !== e.str) begin
            errors++;
            $display("FAIL strobes ph%0d op%0d: got %06b expected %06b at %0t",
                     e.ph, op, {mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc}, e.str, $time);
        end
`ifdef CPU_SEQ_INSTR_CNT_EN
        checks++;
        if (instr_cnt !== e.cnt) begin
            errors++;
            $display("FAIL instr_cnt: got %0d expected %0d at %0t", instr_cnt, e.cnt, $time);
        end
`endif
        if (r) begin
            m_ph = 3'd0;
            m_hl = 1'b0;
            m_cnt = 4'd0;
        end else if (m_hl) begin
            if (g) begin
                m_hl = 1'b0;
                m_ph = 3'd6;
            end
        end else if (m_ph == 3'd4 && op == OP_HLT) begin
            m_hl = 1'b1;
            m_ph = 3'd5;
        end else begin
            if (m_ph == 3'd7) m_cnt = m_cnt + 4'd1;
            m_ph = m_ph + 3'd1;
        end
        @(negedge clk);
    endtask

    task automatic run_instr(input logic [2:0] op, input logic z, input int n);
        repeat (n * 8) step(1'b0, op, z, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b1, OP_ADD, 1'b0, 1'b0);
        step(1'b1, OP_ADD, 1'b0, 1'b1);
        run_instr(OP_ADD, 1'b0, 2);
    endtask

    task automatic test_aluops();
        run_instr(OP_AND, 1'b1, 1);
        run_instr(OP_XOR, 1'b0, 1);
        run_instr(OP_LDA, 1'b1, 1);
    endtask

    task automatic test_skz();
        run_instr(OP_SKZ, 1'b1, 1);
        run_instr(OP_SKZ, 1'b0, 1);
    endtask

    task automatic test_jmp_sto();
        run_instr(OP_JMP, 1'b1, 1);
        run_instr(OP_STO, 1'b0, 1);
    endtask

    task automatic test_halt();
        repeat (5) step(1'b0, OP_HLT, 1'b0, 1'b0);
        repeat (20) step(1'b0, OP_HLT, 1'b0, 1'b0);
        checks++;
        if (halt !== 1'b1 || phase !== 3'd5) begin
            errors++;
            $display("FAIL halt_hold: got halt=%0b phase=%0d expected halt=1 phase=5", halt, phase);
        end
        step(1'b0, OP_HLT, 1'b0, 1'b1);
        repeat (2) step(1'b0, OP_HLT, 1'b0, 1'b0);
        step(1'b0, OP_ADD, 1'b0, 1'b1);
        repeat (7) step(1'b0, OP_ADD, 1'b0, 1'b0);
        // Halt while holding go high and reset on the same cycle: reset must win.
        repeat (5) step(1'b0, OP_HLT, 1'b0, 1'b0);
        step(1'b1, OP_HLT, 1'b0, 1'b1);
        run_instr(OP_ADD, 1'b0, 1);
    endtask

    task automatic test_rst_mid();
        repeat (6) step(1'b0, OP_LDA, 1'b1, 1'b0);
        step(1'b1, OP_LDA, 1'b1, 1'b0);
        checks++;
        if (phase !== 3'd0 || load_ac !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: got phase=%0d load_ac=%0b expected phase=0 load_ac=0", phase, load_ac);
        end
        run_instr(OP_LDA, 1'b1, 1);
    endtask

    task automatic test_back_to_back();
        logic [2:0] op;
        for (int i = 0; i < 12; i++) begin
            op = 3'($urandom_range(1, 7));
            run_instr(op, 1'($urandom_range(0, 1)), 1);
        end
    endtask

    task automatic test_counter();
        step(1'b1, OP_ADD, 1'b0, 1'b0);
        run_instr(OP_ADD, 1'b0, 17);
`ifdef CPU_SEQ_INSTR_CNT_EN
        checks++;
        if (instr_cnt !== 4'd1) begin
            errors++;
            $display("FAIL instr_cnt_wrap: got %0d expected 1", instr_cnt);
        end
`endif
    endtask

    initial begin
        rst = 1'b1;
        opcode = OP_ADD;
        zero = 1'b0;
        go = 1'b0;
        m_ph = 3'd0;
        m_hl = 1'b0;
        m_cnt = 4'd0;
        @(negedge clk);
        test_reset();
        test_aluops();
        test_skz();
        test_jmp_sto();
        test_halt();
        test_rst_mid();
        test_back_to_back();
        test_counter();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
